// File: rtl/rv32f_mem_responder.sv
// rv32f_mem_responder: single-outstanding word memory responder; mem_* request/response side, bus_* core data bus side with wait states and timeout
module rv32f_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [DATA_W-1:0] mem_store,
  output logic              mem_busy,
  output logic [DATA_W-1:0] mem_load,
  output logic              mem_exception,
  output logic              mem_proto_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_ren,
  output logic              bus_wen,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_byte_en,
  input  logic              bus_busy,
  input  logic [DATA_W-1:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, FAULT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, load_q, load_d;
  logic rd_q, rd_d, exc_q, exc_d, perr_q, perr_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    rd_d    = rd_q;
    exc_d   = 1'b0;
    perr_d  = 1'b0;
    case (state_q)
      IDLE: if (mem_ren | mem_wen) begin
        addr_d  = mem_addr;
        wdata_d = mem_store;
        rd_d    = mem_ren;
        perr_d  = mem_ren & mem_wen;
        cnt_d   = '0;
        exc_d   = |mem_addr[1:0];
        state_d = |mem_addr[1:0] ? FAULT : ACCESS;
      end
      ACCESS: if (!bus_busy) begin
        state_d = IDLE;
        load_d  = rd_q ? bus_rdata : load_q;
      end else if (cnt_q == LAST) begin
        state_d = IDLE;
        load_d  = '0;
        exc_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      FAULT: begin
        state_d = IDLE;
        load_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      rd_q    <= 1'b0;
      exc_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      rd_q    <= rd_d;
      exc_q   <= exc_d;
      perr_q  <= perr_d;
    end
  end
  assign mem_busy      = state_q != IDLE;
  assign mem_load      = load_q;
  assign mem_exception = exc_q;
  assign mem_proto_err = perr_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_ren       = (state_q == ACCESS) & rd_q;
  assign bus_wen       = (state_q == ACCESS) & ~rd_q;
  assign bus_byte_en   = {4{state_q == ACCESS}};
endmodule
